// File: rtl/io_bus_fabric.sv
// Memory-mapped I/O interconnect: decodes a single-master request onto one of N
// slave slots with a registered request/ready handshake, timeout watchdog and error capture.
module io_bus_fabric #(
  parameter int                N_SLOTS    = 4,
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                SLOT_SHIFT = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 'h0000_1000,
  parameter int                TIMEOUT    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      m_req,
  input  logic                      m_we,
  input  logic [ADDR_W-1:0]         m_addr,
  input  logic [DATA_W-1:0]         m_wdata,
  output logic [DATA_W-1:0]         m_rdata,
  output logic                      m_ready,
  output logic                      m_err,
  output logic [N_SLOTS-1:0]        s_sel,
  output logic                      s_we,
  output logic [ADDR_W-1:0]         s_addr,
  output logic [DATA_W-1:0]         s_wdata,
  input  logic [N_SLOTS*DATA_W-1:0] s_rdata,
  input  logic [N_SLOTS-1:0]        s_ready,
  output logic [ADDR_W-1:0]         err_addr,
  output logic [7:0]                err_count
);

  localparam int         IDX_W      = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
  localparam int         TAG_LSB    = SLOT_SHIFT + IDX_W;
  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  // Every registered output plus the watchdog counter, reset and updated as one unit.
  typedef struct packed {
    logic [DATA_W-1:0]  rdata;
    logic               ready;
    logic               err;
    logic [N_SLOTS-1:0] sel;
    logic               we;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  wdata;
    logic [ADDR_W-1:0]  err_addr;
    logic [7:0]         err_count;
    logic [7:0]         count;
  } regs_t;

  state_e state, state_nxt;
  regs_t  r_q, r_d;

  logic [IDX_W-1:0]   req_idx;
  logic               req_mapped;
  logic [N_SLOTS-1:0] req_onehot;
  logic               sel_ready;
  logic [DATA_W-1:0]  sel_rdata;
  logic               timed_out;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin : decode
    req_idx    = m_addr[TAG_LSB-1:SLOT_SHIFT];
    req_mapped = (m_addr[ADDR_W-1:TAG_LSB] == BASE_ADDR[ADDR_W-1:TAG_LSB]) &&
                 (32'(req_idx) < N_SLOTS);
    req_onehot = '0;
    for (int k = 0; k < N_SLOTS; k++) begin
      req_onehot[k] = (32'(req_idx) == k);
    end
  end

  // The latched one-hot select steers the read mux; ready from other slots never leaks in.
  always_comb begin : slave_return
    sel_rdata = '0;
    for (int k = 0; k < N_SLOTS; k++) begin
      if (r_q.sel[k]) sel_rdata = s_rdata[k*DATA_W +: DATA_W];
    end
    sel_ready = |(r_q.sel & s_ready);
    timed_out = (r_q.count == LAST_COUNT) && !sel_ready;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or posedge reset) begin : state_reg
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin : next_state
    state_nxt = state;
    case (state)
      IDLE:    if (m_req) state_nxt = req_mapped ? ACCESS : RESP;
      ACCESS:  if (sel_ready || timed_out) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: r_d starts as a copy of r_q so every path assigns every field and
  // no latch can be inferred; branches below only override what changes.
  always_comb begin : output_logic
    r_d       = r_q;
    r_d.ready = 1'b0;
    case (state)
      IDLE: begin
        if (m_req) begin
          r_d.addr  = m_addr;
          r_d.wdata = m_wdata;
          if (req_mapped) begin
            r_d.sel   = req_onehot;
            r_d.we    = m_we;
            r_d.count = 8'd0;
          end else begin
            r_d.err       = 1'b1;
            r_d.rdata     = '0;
            r_d.err_addr  = m_addr;
            r_d.err_count = sat_inc(r_q.err_count);
            r_d.ready     = 1'b1;
          end
        end
      end
      ACCESS: begin
        r_d.count = r_q.count + 8'd1;
        if (sel_ready) begin
          r_d.rdata = r_q.we ? '0 : sel_rdata;
          r_d.err   = 1'b0;
          r_d.sel   = '0;
          r_d.we    = 1'b0;
          r_d.ready = 1'b1;
        end else if (timed_out) begin
          r_d.rdata     = '0;
          r_d.err       = 1'b1;
          r_d.err_addr  = r_q.addr;
          r_d.err_count = sat_inc(r_q.err_count);
          r_d.sel       = '0;
          r_d.we        = 1'b0;
          r_d.ready     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin : regs
    if (reset) r_q <= '0;
    else       r_q <= r_d;
  end

  assign m_rdata   = r_q.rdata;
  assign m_ready   = r_q.ready;
  assign m_err     = r_q.err;
  assign s_sel     = r_q.sel;
  assign s_we      = r_q.we;
  assign s_addr    = r_q.addr;
  assign s_wdata   = r_q.wdata;
  assign err_addr  = r_q.err_addr;
  assign err_count = r_q.err_count;

endmodule

// File: tb/tb_io_bus_fabric.sv
// Self-checking bench for io_bus_fabric: directed vector table, hand-written reset and
// saturation sequences, and randomized transactions checked against a behavioural model.
module tb_io_bus_fabric;

  localparam int          N_SLOTS    = 4;
  localparam int          ADDR_W     = 32;
  localparam int          DATA_W     = 32;
  localparam int          SLOT_SHIFT = 8;
  localparam int          TIMEOUT    = 16;
  localparam logic [31:0] BASE       = 32'h0000_1000;

  logic         clk = 1'b0;
  logic         reset;
  logic         m_req, m_we;
  logic [31:0]  m_addr, m_wdata, m_rdata;
  logic         m_ready, m_err;
  logic [3:0]   s_sel;
  logic         s_we;
  logic [31:0]  s_addr, s_wdata;
  logic [127:0] s_rdata;
  logic [3:0]   s_ready;
  logic [31:0]  err_addr;
  logic [7:0]   err_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0] model_rdata;
  bit          model_err;
  logic [31:0] model_err_addr;
  int          model_err_count;
  bit          in_resp;

  typedef struct {
    int          lat;
    bit          err;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    int          wait_n;
    bit          noise;
    int          lat;
    bit          err;
    logic [31:0] rdata;
  } vec_t;

  io_bus_fabric #(
    .N_SLOTS(N_SLOTS), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .SLOT_SHIFT(SLOT_SHIFT), .BASE_ADDR(BASE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready), .m_err(m_err),
    .s_sel(s_sel), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ready(s_ready),
    .err_addr(err_addr), .err_count(err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Slot window: 1 KiB aligned at BASE, four 256-byte slots.
  function automatic bit mapped(input logic [31:0] a);
    return ((a >> (SLOT_SHIFT + 2)) == (BASE >> (SLOT_SHIFT + 2))) &&
           (((a >> SLOT_SHIFT) % 4) < N_SLOTS);
  endfunction

  function automatic exp_t predict(input logic we, input logic [31:0] a,
                                   input logic [31:0] rd, input int wait_n);
    exp_t e;
    if (!mapped(a)) begin
      e.lat = 1; e.err = 1'b1; e.rdata = 32'h0;
    end else if (wait_n < TIMEOUT) begin
      e.lat = wait_n + 2; e.err = 1'b0; e.rdata = we ? 32'h0 : rd;
    end else begin
      e.lat = TIMEOUT + 1; e.err = 1'b1; e.rdata = 32'h0;
    end
    return e;
  endfunction

  task automatic leave_resp();
    if (in_resp) begin
      @(posedge clk); #1;
      in_resp = 1'b0;
      check("ready_pulse_width", m_ready, 0);
      check("rdata_hold", m_rdata, model_rdata);
      check("err_hold", m_err, model_err);
    end
  endtask

  task automatic idle(input int n);
    m_req = 1'b0;
    leave_resp();
    repeat (n) begin
      @(posedge clk); #1;
      check("idle_ready", m_ready, 0);
    end
  endtask

  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rd, input int wait_n, input bit noise,
                         input exp_t e, output int ready_cyc);
    bit         is_map;
    int         idx;
    logic [3:0] onehot;
    exp_t       m;
    int         lat;
    bit         done;
    is_map = mapped(addr);
    idx    = int'((addr >> SLOT_SHIFT) % 4);
    onehot = is_map ? (4'b0001 << idx) : 4'b0000;
    m      = predict(we, addr, rd, wait_n);
    lat    = 0;
    done   = 1'b0;
    for (int k = 0; k < N_SLOTS; k++) s_rdata[k*32 +: 32] = $urandom;
    if (is_map) s_rdata[idx*32 +: 32] = rd;
    m_we = we; m_addr = addr; m_wdata = wdata; s_ready = 4'b0; m_req = 1'b1;
    leave_resp();
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        m_addr  = $urandom;
        m_wdata = $urandom;
        if (noise) m_req = 1'b0;
      end
      if (m_ready) done = 1'b1;
      else begin
        check("sel_we", {s_sel, s_we}, {onehot, we});
        check("s_addr", s_addr, addr);
        check("s_wdata", s_wdata, wdata);
        s_ready = noise ? (4'($urandom) & ~onehot) : 4'b0000;
        if (is_map && (lat - 1) == wait_n) s_ready = s_ready | onehot;
      end
    end
    m_req     = 1'b0;
    s_ready   = 4'b0;
    ready_cyc = cyc;
    if (m.err) begin
      model_err_count = (model_err_count < 255) ? model_err_count + 1 : 255;
      model_err_addr  = addr;
    end
    model_rdata = m.rdata;
    model_err   = m.err;
    check("ready_seen", done, 1);
    check("latency", lat, e.lat);
    check("m_err", m_err, e.err);
    check("m_rdata", m_rdata, e.rdata);
    check("sel_dropped", {s_sel, s_we}, 0);
    check("err_addr", err_addr, model_err_addr);
    check("err_count", err_count, model_err_count);
    in_resp = 1'b1;
  endtask

  initial begin
    vec_t        vecs [9];
    exp_t        e;
    int          rc, prev;
    logic [31:0] a;

    vecs[0] = '{1'b0, 32'h1104, 32'h0000_0000, 32'hDEAD_BEEF,  0, 1'b0,  2, 1'b0, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 32'h1200, 32'h0000_0055, 32'h1111_2222,  3, 1'b0,  5, 1'b0, 32'h0};
    vecs[2] = '{1'b0, 32'h2000, 32'h0000_0000, 32'h3333_4444,  0, 1'b0,  1, 1'b1, 32'h0};
    vecs[3] = '{1'b0, 32'h1300, 32'h0000_0000, 32'hCAFE_0003, 99, 1'b1, 17, 1'b1, 32'h0};
    vecs[4] = '{1'b0, 32'h1000, 32'h0000_0000, 32'hA5A5_0001, 15, 1'b1, 17, 1'b0, 32'hA5A5_0001};
    vecs[5] = '{1'b0, 32'h13FC, 32'h0000_0000, 32'h1234_5678,  1, 1'b0,  3, 1'b0, 32'h1234_5678};
    vecs[6] = '{1'b1, 32'h0FFC, 32'h0000_00AA, 32'h5555_6666,  0, 1'b0,  1, 1'b1, 32'h0};
    vecs[7] = '{1'b0, 32'h1400, 32'h0000_0000, 32'h7777_8888,  0, 1'b0,  1, 1'b1, 32'h0};
    vecs[8] = '{1'b1, 32'h10F0, 32'hFFFF_0000, 32'h9999_AAAA, 16, 1'b0, 17, 1'b1, 32'h0};

    reset = 1'b1; m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
    s_rdata = '0; s_ready = '0; in_resp = 1'b0;
    model_rdata = '0; model_err = 1'b0; model_err_addr = '0; model_err_count = 0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready_err", {m_ready, m_err}, 0);
    check("rst_rdata", m_rdata, 0);
    check("rst_sel_we", {s_sel, s_we}, 0);
    check("rst_s_addr", s_addr, 0);
    check("rst_s_wdata", s_wdata, 0);
    check("rst_err_addr", err_addr, 0);
    check("rst_err_count", err_count, 0);
    reset = 1'b0;
    idle(1);

    foreach (vecs[i]) begin
      e = '{vecs[i].lat, vecs[i].err, vecs[i].rdata};
      run_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rd,
              vecs[i].wait_n, vecs[i].noise, e, rc);
    end
    idle(2);

    for (int i = 0; i < 200; i++) begin
      int          slot, wait_n, gap;
      logic        we;
      bit          noise;
      logic [31:0] rd, wd;
      slot   = $urandom_range(0, 3);
      a      = ($urandom_range(0, 9) < 7) ? (BASE | 32'(slot << 8) | ($urandom & 32'hFC))
                                          : 32'($urandom);
      wait_n = ($urandom_range(0, 7) == 0) ? $urandom_range(13, 20) : $urandom_range(0, 4);
      we     = 1'($urandom);
      noise  = 1'($urandom);
      rd     = $urandom;
      wd     = $urandom;
      gap    = $urandom_range(0, 2);
      if (gap > 0) idle(gap);
      e = predict(we, a, rd, wait_n);
      run_txn(we, a, wd, rd, wait_n, noise, e, rc);
    end

    // Reset during the second ACCESS cycle of a never-ready read to slot 2.
    idle(1);
    m_we = 1'b0; m_addr = 32'h1200; m_wdata = 32'h0; s_ready = 4'b0; m_req = 1'b1;
    @(posedge clk); #1;
    m_req = 1'b0;
    check("pre_reset_sel", s_sel, 4'b0100);
    @(posedge clk); #1;
    check("pre_reset_still_access", {s_sel, m_ready}, {4'b0100, 1'b0});
    #2 reset = 1'b1;
    #1;
    check("async_rst_sel_we", {s_sel, s_we}, 0);
    check("async_rst_ready", m_ready, 0);
    check("async_rst_err_count", err_count, 0);
    check("async_rst_s_addr", s_addr, 0);
    check("async_rst_rdata", m_rdata, 0);
    @(posedge clk); #1;
    check("rst_no_completion", m_ready, 0);
    reset = 1'b0;
    model_rdata = '0; model_err = 1'b0; model_err_addr = '0; model_err_count = 0;
    in_resp = 1'b0;
    idle(1);
    e = '{4, 1'b0, 32'h0BAD_F00D};
    run_txn(1'b0, 32'h1010, 32'h0, 32'h0BAD_F00D, 2, 1'b0, e, rc);

    // 260 unmapped accesses back-to-back: 2-cycle period, counter saturates at 255.
    prev = 0;
    for (int i = 0; i < 260; i++) begin
      a = 32'h8000_0000 | ($urandom & 32'h7FFF_FFFC);
      e = predict(1'b0, a, 32'h0, 0);
      run_txn(1'b0, a, $urandom, 32'h0, 0, 1'b0, e, rc);
      if (i > 0) check("b2b_period", rc - prev, 2);
      prev = rc;
    end
    check("err_count_saturated", err_count, 255);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
